// File: rtl/fx_bus_mux.sv
// Registered fx bus fabric: broadcasts master writes/reads with one-hot selects and returns read data.
// Latency: writes 1 cycle; reads RD_LAT+2 cycles to ufx_q_vld. No backpressure: a read arriving while busy is dropped and flagged.
module fx_bus_mux #(
   parameter int             NSLV    = 36,
   parameter int             AW      = 22,
   parameter int             DW      = 8,
   parameter int             SEL_LSB = 16,
   parameter int             RD_LAT  = 2,
   parameter logic [DW-1:0]  ERR_Q   = DW'('hEE)
) (
   input  logic                 clk_sys,
   input  logic                 rst_n,
   input  logic                 ufx_wr,
   input  logic [AW-1:0]        ufx_waddr,
   input  logic [DW-1:0]        ufx_data,
   input  logic                 ufx_rd,
   input  logic [AW-1:0]        ufx_raddr,
   output logic [DW-1:0]        ufx_q,
   output logic                 ufx_q_vld,
   output logic                 ufx_busy,
   output logic                 ufx_err,
   output logic                 ufx_drop,
   output logic                 fx_wr,
   output logic [AW-1:0]        fx_waddr,
   output logic [DW-1:0]        fx_data,
   output logic [NSLV-1:0]      fx_wsel,
   output logic                 fx_rd,
   output logic [AW-1:0]        fx_raddr,
   output logic [NSLV-1:0]      fx_rsel,
   input  logic [NSLV*DW-1:0]   fx_q_bus
);

   localparam int IW = AW - SEL_LSB;
   localparam int CW = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RET} state_t;

   function automatic logic [31:0] idx_ext(input logic [IW-1:0] i);
      idx_ext = '0;
      idx_ext[IW-1:0] = i;
   endfunction

   // Full-width compare so an index past NSLV never aliases onto a real slave.
   function automatic logic is_mapped(input logic [IW-1:0] i);
      is_mapped = (idx_ext(i) < 32'(NSLV));
   endfunction

   function automatic logic [NSLV-1:0] decode(input logic [IW-1:0] i);
      decode = '0;
      for (int k = 0; k < NSLV; k++) decode[k] = (idx_ext(i) == 32'(k));
   endfunction

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              mapped_q, mapped_d;
   logic              fx_wr_q, fx_wr_d;
   logic [AW-1:0]     fx_waddr_q, fx_waddr_d;
   logic [DW-1:0]     fx_data_q, fx_data_d;
   logic [NSLV-1:0]   fx_wsel_q, fx_wsel_d;
   logic              fx_rd_q, fx_rd_d;
   logic [AW-1:0]     fx_raddr_q, fx_raddr_d;
   logic [NSLV-1:0]   fx_rsel_q, fx_rsel_d;
   logic [DW-1:0]     ufx_q_q, ufx_q_d;
   logic              ufx_q_vld_q, ufx_q_vld_d;
   logic              ufx_busy_q, ufx_busy_d;
   logic              ufx_err_q, ufx_err_d;
   logic              ufx_drop_q, ufx_drop_d;
   logic [DW-1:0]     rdat;

   always_comb begin
      rdat = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (idx_ext(idx_q) == 32'(k)) rdat = fx_q_bus[k*DW +: DW];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      mapped_d    = mapped_q;
      fx_wr_d     = ufx_wr;
      fx_waddr_d  = fx_waddr_q;
      fx_data_d   = fx_data_q;
      fx_wsel_d   = fx_wsel_q;
      fx_rd_d     = 1'b0;
      fx_raddr_d  = fx_raddr_q;
      fx_rsel_d   = fx_rsel_q;
      ufx_q_d     = ufx_q_q;
      ufx_q_vld_d = 1'b0;
      ufx_busy_d  = ufx_busy_q;
      ufx_err_d   = 1'b0;
      ufx_drop_d  = 1'b0;

      if (ufx_wr) begin
         fx_waddr_d = ufx_waddr;
         fx_data_d  = ufx_data;
         fx_wsel_d  = decode(ufx_waddr[AW-1:SEL_LSB]);
      end

      case (state_q)
         IDLE: begin
            if (ufx_rd) begin
               fx_rd_d    = 1'b1;
               fx_raddr_d = ufx_raddr;
               fx_rsel_d  = decode(ufx_raddr[AW-1:SEL_LSB]);
               idx_d      = ufx_raddr[AW-1:SEL_LSB];
               mapped_d   = is_mapped(ufx_raddr[AW-1:SEL_LSB]);
               cnt_d      = CW'(RD_LAT);
               ufx_busy_d = 1'b1;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            ufx_drop_d = ufx_rd;
            cnt_d      = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = RET;
         end
         RET: begin
            ufx_drop_d  = ufx_rd;
            ufx_q_d     = mapped_q ? rdat : ERR_Q;
            ufx_q_vld_d = 1'b1;
            ufx_err_d   = ~mapped_q;
            ufx_busy_d  = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         mapped_q    <= 1'b0;
         fx_wr_q     <= 1'b0;
         fx_waddr_q  <= '0;
         fx_data_q   <= '0;
         fx_wsel_q   <= '0;
         fx_rd_q     <= 1'b0;
         fx_raddr_q  <= '0;
         fx_rsel_q   <= '0;
         ufx_q_q     <= '0;
         ufx_q_vld_q <= 1'b0;
         ufx_busy_q  <= 1'b0;
         ufx_err_q   <= 1'b0;
         ufx_drop_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         mapped_q    <= mapped_d;
         fx_wr_q     <= fx_wr_d;
         fx_waddr_q  <= fx_waddr_d;
         fx_data_q   <= fx_data_d;
         fx_wsel_q   <= fx_wsel_d;
         fx_rd_q     <= fx_rd_d;
         fx_raddr_q  <= fx_raddr_d;
         fx_rsel_q   <= fx_rsel_d;
         ufx_q_q     <= ufx_q_d;
         ufx_q_vld_q <= ufx_q_vld_d;
         ufx_busy_q  <= ufx_busy_d;
         ufx_err_q   <= ufx_err_d;
         ufx_drop_q  <= ufx_drop_d;
      end
   end

   assign ufx_q     = ufx_q_q;
   assign ufx_q_vld = ufx_q_vld_q;
   assign ufx_busy  = ufx_busy_q;
   assign ufx_err   = ufx_err_q;
   assign ufx_drop  = ufx_drop_q;
   assign fx_wr     = fx_wr_q;
   assign fx_waddr  = fx_waddr_q;
   assign fx_data   = fx_data_q;
   assign fx_wsel   = fx_wsel_q;
   assign fx_rd     = fx_rd_q;
   assign fx_raddr  = fx_raddr_q;
   assign fx_rsel   = fx_rsel_q;

endmodule

// File: tb/tb_fx_bus_mux.sv
// Bench for fx_bus_mux with four slaves: vector table, read-return scoreboard, drop and mid-read reset sequences.
module tb_fx_bus_mux;

   localparam int NSLV = 4;
   localparam int AW   = 22;
   localparam int DW   = 8;

   logic              clk_sys = 1'b0;
   logic              rst_n;
   logic              ufx_wr, ufx_rd;
   logic [AW-1:0]     ufx_waddr, ufx_raddr;
   logic [DW-1:0]     ufx_data;
   logic [DW-1:0]     ufx_q;
   logic              ufx_q_vld, ufx_busy, ufx_err, ufx_drop;
   logic              fx_wr, fx_rd;
   logic [AW-1:0]     fx_waddr, fx_raddr;
   logic [DW-1:0]     fx_data;
   logic [NSLV-1:0]   fx_wsel, fx_rsel;
   logic [NSLV*DW-1:0] fx_q_bus;

   // Slave 3..0 read data.
   assign fx_q_bus = {8'h3C, 8'h96, 8'hC3, 8'h5A};

   always #5 clk_sys = ~clk_sys;

   fx_bus_mux #(.NSLV(NSLV), .AW(AW), .DW(DW), .SEL_LSB(16), .RD_LAT(2), .ERR_Q(8'hEE)) dut (
      .clk_sys(clk_sys), .rst_n(rst_n),
      .ufx_wr(ufx_wr), .ufx_waddr(ufx_waddr), .ufx_data(ufx_data),
      .ufx_rd(ufx_rd), .ufx_raddr(ufx_raddr),
      .ufx_q(ufx_q), .ufx_q_vld(ufx_q_vld), .ufx_busy(ufx_busy),
      .ufx_err(ufx_err), .ufx_drop(ufx_drop),
      .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data), .fx_wsel(fx_wsel),
      .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_rsel(fx_rsel),
      .fx_q_bus(fx_q_bus)
   );

   typedef struct {
      logic          wr;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic          rd;
      logic [AW-1:0] raddr;
      logic [3:0]    exp_wsel;
      logic [3:0]    exp_rsel;
      logic [DW-1:0] exp_q;
      logic          exp_err;
   } vec_t;

   typedef struct {
      logic [DW-1:0] q;
      logic          err;
      int            cyc;
   } sb_t;

   int  n_vec = 0;
   int  n_err = 0;
   int  cyc   = 0;
   sb_t sb[$];
   vec_t vecs[8];

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Every read return must match the oldest outstanding expectation, including its cycle.
   always @(negedge clk_sys) begin
      if (rst_n && ufx_q_vld) begin
         if (sb.size() == 0) begin
            chk("unexpected_vld", 32'(ufx_q_vld), 32'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk("rd_q", 32'(ufx_q), 32'(e.q));
            chk("rd_err", 32'(ufx_err), 32'(e.err));
            chk("rd_cycle", 32'(cyc), 32'(e.cyc));
         end
      end else if (rst_n) begin
         chk("err_without_vld", 32'(ufx_err), 32'd0);
      end
   end

   task automatic apply(input vec_t v);
      int c;
      @(negedge clk_sys);
      c = cyc;
      ufx_wr = v.wr; ufx_waddr = v.waddr; ufx_data = v.wdata;
      ufx_rd = v.rd; ufx_raddr = v.raddr;
      if (v.rd) sb.push_back('{v.exp_q, v.exp_err, c + 4});
      @(negedge clk_sys);
      ufx_wr = 1'b0; ufx_rd = 1'b0;
      chk("fx_wr", 32'(fx_wr), 32'(v.wr));
      chk("fx_rd", 32'(fx_rd), 32'(v.rd));
      chk("busy_t1", 32'(ufx_busy), 32'(v.rd));
      if (v.wr) begin
         chk("fx_waddr", 32'(fx_waddr), 32'(v.waddr));
         chk("fx_data", 32'(fx_data), 32'(v.wdata));
         chk("fx_wsel", 32'(fx_wsel), 32'(v.exp_wsel));
      end
      if (v.rd) begin
         chk("fx_raddr", 32'(fx_raddr), 32'(v.raddr));
         chk("fx_rsel", 32'(fx_rsel), 32'(v.exp_rsel));
      end
      @(negedge clk_sys);
      chk("fx_wr_pulse", 32'(fx_wr), 32'd0);
      chk("fx_rd_pulse", 32'(fx_rd), 32'd0);
      if (v.wr) chk("fx_waddr_hold", 32'(fx_waddr), 32'(v.waddr));
      if (v.rd) begin
         chk("busy_t2", 32'(ufx_busy), 32'd1);
         @(negedge clk_sys);
         chk("busy_t3", 32'(ufx_busy), 32'd1);
         @(negedge clk_sys);
         chk("busy_t4", 32'(ufx_busy), 32'd0);
         chk("vld_t4", 32'(ufx_q_vld), 32'd1);
         @(negedge clk_sys);
         chk("vld_t5", 32'(ufx_q_vld), 32'd0);
      end
   endtask

   initial begin
      int c;
      vecs[0] = '{1'b1, 22'h020005, 8'h5A, 1'b0, 22'h000000, 4'b0100, 4'b0000, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 22'h000000, 8'h00, 1'b1, 22'h010003, 4'b0000, 4'b0010, 8'hC3, 1'b0};
      vecs[2] = '{1'b0, 22'h000000, 8'h00, 1'b1, 22'h070000, 4'b0000, 4'b0000, 8'hEE, 1'b1};
      vecs[3] = '{1'b1, 22'h000001, 8'hA5, 1'b1, 22'h030002, 4'b0001, 4'b1000, 8'h3C, 1'b0};
      vecs[4] = '{1'b1, 22'h3F1234, 8'h77, 1'b0, 22'h000000, 4'b0000, 4'b0000, 8'h00, 1'b0};
      vecs[5] = '{1'b0, 22'h000000, 8'h00, 1'b1, 22'h000000, 4'b0000, 4'b0001, 8'h5A, 1'b0};
      vecs[6] = '{1'b0, 22'h000000, 8'h00, 1'b1, 22'h04FFFF, 4'b0000, 4'b0000, 8'hEE, 1'b1};
      vecs[7] = '{1'b1, 22'h02FFFF, 8'h01, 1'b1, 22'h02ABCD, 4'b0100, 4'b0100, 8'h96, 1'b0};

      rst_n = 1'b0; ufx_wr = 1'b0; ufx_rd = 1'b0;
      ufx_waddr = '0; ufx_raddr = '0; ufx_data = '0;
      #3;
      chk("rst_outputs",
          32'({ufx_q, ufx_q_vld, ufx_busy, ufx_err, ufx_drop, fx_wr, fx_rd, fx_wsel, fx_rsel}), 32'd0);
      chk("rst_fx_waddr", 32'(fx_waddr), 32'd0);
      chk("rst_fx_raddr", 32'(fx_raddr), 32'd0);
      chk("rst_fx_data", 32'(fx_data), 32'd0);
      @(negedge clk_sys);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) apply(vecs[i]);

      // Drop while busy; write proceeds; read in the return cycle is accepted.
      @(negedge clk_sys);
      c = cyc;
      ufx_rd = 1'b1; ufx_raddr = 22'h010003;
      sb.push_back('{8'hC3, 1'b0, c + 4});
      @(negedge clk_sys);
      ufx_rd = 1'b0;
      chk("drop_fx_rd_t1", 32'(fx_rd), 32'd1);
      @(negedge clk_sys);
      ufx_rd = 1'b1; ufx_raddr = 22'h020000;
      ufx_wr = 1'b1; ufx_waddr = 22'h010010; ufx_data = 8'hE1;
      chk("drop_t2", 32'(ufx_drop), 32'd0);
      @(negedge clk_sys);
      ufx_rd = 1'b0; ufx_wr = 1'b0;
      chk("drop_t3", 32'(ufx_drop), 32'd1);
      chk("drop_no_fx_rd", 32'(fx_rd), 32'd0);
      chk("drop_rsel_hold", 32'(fx_rsel), 32'b0010);
      chk("drop_raddr_hold", 32'(fx_raddr), 32'h010003);
      chk("drop_wr_pass", 32'(fx_wr), 32'd1);
      chk("drop_wsel", 32'(fx_wsel), 32'b0010);
      chk("drop_busy_t3", 32'(ufx_busy), 32'd1);
      @(negedge clk_sys);
      ufx_rd = 1'b1; ufx_raddr = 22'h030000;
      sb.push_back('{8'h3C, 1'b0, c + 8});
      chk("drop_t4", 32'(ufx_drop), 32'd0);
      chk("busy_t4_b2b", 32'(ufx_busy), 32'd0);
      @(negedge clk_sys);
      ufx_rd = 1'b0;
      chk("b2b_fx_rd_t5", 32'(fx_rd), 32'd1);
      chk("b2b_rsel_t5", 32'(fx_rsel), 32'b1000);
      chk("b2b_busy_t5", 32'(ufx_busy), 32'd1);
      chk("b2b_drop_t5", 32'(ufx_drop), 32'd0);
      repeat (5) @(negedge clk_sys);
      chk("sb_empty_b2b", 32'(sb.size()), 32'd0);

      // Reset mid-read abandons the transaction.
      @(negedge clk_sys);
      c = cyc;
      ufx_rd = 1'b1; ufx_raddr = 22'h000000;
      sb.push_back('{8'h5A, 1'b0, c + 4});
      @(negedge clk_sys);
      ufx_rd = 1'b0;
      chk("rstrd_fx_rd_t1", 32'(fx_rd), 32'd1);
      @(negedge clk_sys);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("rstrd_busy", 32'(ufx_busy), 32'd0);
      chk("rstrd_q", 32'(ufx_q), 32'd0);
      chk("rstrd_sel", 32'({fx_wsel, fx_rsel}), 32'd0);
      chk("rstrd_addr", 32'(fx_raddr | fx_waddr), 32'd0);
      chk("rstrd_data", 32'(fx_data), 32'd0);
      repeat (2) @(negedge clk_sys);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_sys);
         chk("rstrd_no_vld", 32'(ufx_q_vld), 32'd0);
         chk("rstrd_no_busy", 32'(ufx_busy), 32'd0);
      end
      chk("sb_empty_end", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fx_bus_mux.md
Name: fx_bus_mux

Overview:
Parametrised, registered successor of the flat fx bus interconnect between the UART fx master and N fx slaves. Master requests are registered and broadcast to all slaves. A one-hot per-slave select is decoded from the upper address bits. Read data returns through an indexed mux after a fixed slave latency instead of an OR-reduction, with valid, busy, unmapped-error and dropped-request reporting. Sits between the UART master and the con/app/ad/dsp/p/ast/chip/pkg slaves.

Parameters:
NSLV, 36, number of slaves (1..64)
AW, 22, address width
DW, 8, data width
SEL_LSB, 16, slave index = addr[AW-1:SEL_LSB]
RD_LAT, 2, cycles from fx_rd high to slave q valid (1..8)
ERR_Q, 8'hEE, data returned for an unmapped read

Ports:
clk_sys  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ufx_wr  in  1  master write strobe, 1-cycle pulse
ufx_waddr  in  AW  master write address
ufx_data  in  DW  master write data
ufx_rd  in  1  master read strobe, 1-cycle pulse
ufx_raddr  in  AW  master read address
ufx_q  out  DW  read data, held until next return
ufx_q_vld  out  1  1-cycle pulse, ufx_q updated
ufx_busy  out  1  read outstanding
ufx_err  out  1  1-cycle pulse with ufx_q_vld when the read was unmapped
ufx_drop  out  1  1-cycle pulse, read rejected while busy
fx_wr  out  1  registered write strobe to slaves
fx_waddr  out  AW  registered write address
fx_data  out  DW  registered write data
fx_wsel  out  NSLV  one-hot write select (all 0 if unmapped)
fx_rd  out  1  registered read strobe to slaves
fx_raddr  out  AW  registered read address
fx_rsel  out  NSLV  one-hot read select
fx_q_bus  in  NSLV*DW  slave read data, slave k at [k*DW +: DW]

Behaviour:
- Reset (async, rst_n low): all outputs 0, including ufx_q; read FSM to IDLE; latency counter 0.
- Write path, 1-cycle latency: cycle after ufx_wr=1, fx_wr=1 with fx_waddr, fx_data and fx_wsel registered. fx_waddr/fx_data hold their last value when ufx_wr=0. fx_wsel is all-zero when the index is >= NSLV; fx_wr still pulses. Writes are never blocked by reads.
- Read FSM: IDLE, WAIT, RET.
  - IDLE: ufx_rd=1 registers fx_rd=1 (one cycle), fx_raddr, fx_rsel; stores index and a mapped flag; loads cnt=RD_LAT; ufx_busy=1 from the next cycle; goes to WAIT.
  - WAIT: cnt decrements each cycle. Transition to RET when cnt reaches 1.
  - RET: samples fx_q_bus[idx*DW +: DW]; ufx_q takes that value (ERR_Q if unmapped) on the next edge. ufx_q_vld=1 and ufx_err=mapped?0:1 for exactly that cycle. ufx_busy falls the same cycle; FSM returns to IDLE.
  - Total: ufx_rd at cycle t gives ufx_q_vld at cycle t+RD_LAT+2.
- ufx_rd=1 while busy (WAIT or RET): request ignored, no fx_rd, ufx_drop=1 next cycle.
- ufx_rd in the same cycle as ufx_q_vld is accepted, because the FSM is in IDLE then.
- Simultaneous ufx_wr and ufx_rd: both forwarded in the same cycle, independently.
- fx_rsel holds until the next accepted read. fx_raddr holds likewise.
- Index width is AW-SEL_LSB. Compare against NSLV at full width; no truncation or wrap-around.
- rst_n asserted mid-read: the read is abandoned; no ufx_q_vld is generated after release.

Test Plan:
- NSLV=4, SEL_LSB=16, RD_LAT=2: ufx_wr, waddr=22'h020005, data=8'h5A at t0 -> t1: fx_wr=1, fx_waddr=22'h020005, fx_data=8'h5A, fx_wsel=4'b0100.
- Read raddr=22'h010003 at t0 with slave1 q=8'hC3 -> fx_rd=1 and fx_rsel=4'b0010 at t1; ufx_q_vld=1, ufx_q=8'hC3, ufx_err=0 at t4; ufx_busy high t1..t3.
- Read raddr=22'h070000 (index 7 >= 4) -> fx_rsel=0; at t4 ufx_q=8'hEE, ufx_q_vld=1, ufx_err=1.
- Second ufx_rd at t2 during busy -> ufx_drop=1 at t3, no second fx_rd. A third ufx_rd at t4 is accepted, giving fx_rd=1 at t5.
- ufx_wr and ufx_rd in the same cycle to slaves 0 and 3 -> fx_wr and fx_rd both pulse next cycle with the correct selects.
- rst_n low at t2 during a read -> all outputs 0 immediately; no ufx_q_vld after release.
